// File: rtl/sign_cmp_arbiter.sv
// sign_cmp_arbiter
// Round-robin scheduler that shares one external signed comparator among
// NREQ requesters. A granted operand pair is registered onto CMP_A/CMP_B.
// AGEB is captured one cycle later and returned with a one-cycle ACK pulse.
module sign_cmp_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input  logic                    SYSCLK,
    input  logic                    NSYSRESET,
    input  logic [NREQ-1:0]         REQ,
    input  logic [NREQ*WIDTH-1:0]   OPA,
    input  logic [NREQ*WIDTH-1:0]   OPB,
    output logic [NREQ-1:0]         ACK,
    output logic                    RESULT,
    output logic                    BUSY,
    output logic [WIDTH-1:0]        CMP_A,
    output logic [WIDTH-1:0]        CMP_B,
    input  logic                    CMP_AGEB
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   gnt;
    logic [PW-1:0]   sel;
    logic            found;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic            load;
    logic            capture;

    // Round-robin search: first requester at or after ptr, wrapping mod NREQ.
    // NOTE: every output of an always_comb gets a default before any branch,
    // so no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        int idx;
        idx   = 0;
        found = 1'b0;
        sel   = ptr;
        // Walk offsets from farthest to nearest so the nearest hit wins.
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (REQ[idx]) begin
                found = 1'b1;
                sel   = PW'(idx);
            end
        end
    end

    // Operand mux: pick slice sel out of the packed OPA/OPB buses.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (sel == PW'(i)) begin
                sel_a = OPA[i*WIDTH +: WIDTH];
                sel_b = OPB[i*WIDTH +: WIDTH];
            end
        end
    end

    // Next-state logic and the load/capture strobes for the datapath.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    load      = 1'b1;
                    state_nxt = CMP;
                end
            end
            CMP: begin
                capture   = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register; reset drops any in-flight transaction.
    // NOTE: sequential state uses non-blocking assignments so every register
    // sees pre-edge values regardless of evaluation order.
    always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
        if (!NSYSRESET) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath: latch grant and operands in IDLE, capture AGEB in CMP.
    // CMP_A/CMP_B only change on a load, so the comparator sees stable
    // inputs for the whole CMP cycle; ACK is cleared on every non-capture edge.
    always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
        if (!NSYSRESET) begin
            gnt    <= '0;
            ptr    <= '0;
            CMP_A  <= '0;
            CMP_B  <= '0;
            RESULT <= 1'b0;
            ACK    <= '0;
        end else begin
            if (load) begin
                gnt   <= sel;
                CMP_A <= sel_a;
                CMP_B <= sel_b;
            end
            if (capture) begin
                RESULT <= CMP_AGEB;
                ACK    <= {{(NREQ-1){1'b0}}, 1'b1} << gnt;
                ptr    <= (gnt == PW'(NREQ - 1)) ? '0 : gnt + 1'b1;
            end else begin
                ACK    <= '0;
            end
        end
    end

    assign BUSY = (state != IDLE);

endmodule

// File: tb/tb_sign_cmp_arbiter.sv
// tb_sign_cmp_arbiter
// Directed stimulus with a scoreboard: expected {ACK, RESULT} pairs are queued
// when requests are issued; a monitor pops and compares on every ACK pulse.
// The comparator itself is modelled here as a signed >= on CMP_A/CMP_B.
module tb_sign_cmp_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;

    logic                  SYSCLK = 1'b0;
    logic                  NSYSRESET;
    logic [NREQ-1:0]       REQ;
    logic [NREQ*WIDTH-1:0] OPA;
    logic [NREQ*WIDTH-1:0] OPB;
    logic [NREQ-1:0]       ACK;
    logic                  RESULT;
    logic                  BUSY;
    logic [WIDTH-1:0]      CMP_A;
    logic [WIDTH-1:0]      CMP_B;
    logic                  CMP_AGEB;

    typedef struct {
        logic [NREQ-1:0] ack;
        logic            result;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    sign_cmp_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .SYSCLK    (SYSCLK),
        .NSYSRESET (NSYSRESET),
        .REQ       (REQ),
        .OPA       (OPA),
        .OPB       (OPB),
        .ACK       (ACK),
        .RESULT    (RESULT),
        .BUSY      (BUSY),
        .CMP_A     (CMP_A),
        .CMP_B     (CMP_B),
        .CMP_AGEB  (CMP_AGEB)
    );

    // Reference comparator: two's-complement A >= B.
    assign CMP_AGEB = ($signed(CMP_A) >= $signed(CMP_B));

    always #5 SYSCLK = ~SYSCLK;

    always @(posedge SYSCLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every ACK pulse must match the head of the scoreboard.
    always @(negedge SYSCLK) begin
        if (ACK !== '0) begin
            check("ack_onehot", $countones(ACK), 1);
            if (q.size() == 0) begin
                check("unexpected_ack", ACK, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("ack_value", ACK, e.ack);
                check("result_value", RESULT, e.result);
            end
        end
    end

    task automatic set_ops(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        OPA[i*WIDTH +: WIDTH] = a;
        OPB[i*WIDTH +: WIDTH] = b;
    endtask

    task automatic push(input logic [NREQ-1:0] ack, input logic res);
        exp_t e;
        e.ack    = ack;
        e.result = res;
        q.push_back(e);
    endtask

    // Waits (bounded) for ACK[i], drops REQ[i] in the ACK cycle, returns the
    // number of negedges from the call to the ACK cycle.
    task automatic wait_ack(input int i, output int lat);
        lat = -1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge SYSCLK);
            if (ACK[i]) begin
                lat    = k;
                REQ[i] = 1'b0;
                break;
            end
        end
        if (lat < 0) check("ack_timeout", 0, 1);
    endtask

    // One isolated transaction issued from an IDLE cycle; ACK lands two
    // negedges later (grant edge, then capture edge).
    task automatic run_one(input int i, input logic [WIDTH-1:0] a,
                           input logic [WIDTH-1:0] b, input logic res);
        int lat;
        set_ops(i, a, b);
        push(NREQ'(1) << i, res);
        REQ[i] = 1'b1;
        wait_ack(i, lat);
        check("latency", lat, 2);
        @(negedge SYSCLK);
        check("idle_after_ack", {BUSY, ACK}, 0);
    endtask

    initial begin
        int lat;
        int n;
        int last;
        int reraise;
        int idx;

        NSYSRESET = 1'b0;
        REQ = '0;
        OPA = '0;
        OPB = '0;
        #2;
        check("reset_outputs", {ACK, RESULT, BUSY, CMP_A, CMP_B}, 0);
        repeat (2) @(negedge SYSCLK);
        NSYSRESET = 1'b1;
        @(negedge SYSCLK);

        // Single request: -1 vs 1 -> 0; operands visible one cycle after sampling.
        set_ops(0, 8'hFF, 8'h01);
        push(4'b0001, 1'b0);
        REQ[0] = 1'b1;
        @(negedge SYSCLK);
        check("cmp_a_load", CMP_A, 8'hFF);
        check("cmp_b_load", CMP_B, 8'h01);
        check("busy_cmp", BUSY, 1);
        check("no_early_ack", ACK, 0);
        @(negedge SYSCLK);
        check("single_ack", ACK, 4'b0001);
        REQ[0] = 1'b0;
        @(negedge SYSCLK);
        check("idle_after_single", {BUSY, ACK}, 0);

        // Signed boundaries on requester 2.
        run_one(2, 8'h7F, 8'h80, 1'b1);
        run_one(2, 8'h80, 8'h7F, 1'b0);
        run_one(2, 8'h80, 8'h80, 1'b1);

        // Rotation with all four requesters; ptr is 3 after the last grant to 2.
        run_one(3, 8'h01, 8'h02, 1'b0);
        set_ops(0, 8'h05, 8'h03);
        set_ops(1, 8'hF0, 8'h10);
        set_ops(2, 8'h00, 8'h00);
        set_ops(3, 8'h80, 8'hFF);
        push(4'b0001, 1'b1);
        push(4'b0010, 1'b0);
        push(4'b0100, 1'b1);
        push(4'b1000, 1'b0);
        push(4'b0001, 1'b1);
        REQ = '1;
        n = 0;
        last = -1;
        reraise = -1;
        for (int bud = 0; bud < 40 && n < 5; bud++) begin
            @(negedge SYSCLK);
            if (reraise >= 0) begin
                REQ[reraise] = 1'b1;
                reraise = -1;
            end
            if (ACK != '0) begin
                idx = 0;
                for (int i = 0; i < NREQ; i++) if (ACK[i]) idx = i;
                check("busy_in_done", BUSY, 1);
                if (last >= 0) check("ack_spacing", cyc - last, 3);
                last = cyc;
                REQ[idx] = 1'b0;
                reraise = idx;
                n++;
            end else if (last >= 0 && cyc == last + 1) begin
                check("busy_low_idle", BUSY, 0);
            end
        end
        if (n < 5) check("rotation_timeout", n, 5);
        REQ = '0;
        repeat (2) @(negedge SYSCLK);

        // Early release: REQ1 dropped and OPA1 changed during CMP.
        set_ops(1, 8'h10, 8'h20);
        push(4'b0010, 1'b0);
        REQ[1] = 1'b1;
        @(negedge SYSCLK);
        REQ[1] = 1'b0;
        set_ops(1, 8'h7F, 8'h20);
        wait_ack(1, lat);
        check("early_release_latency", lat, 1);
        @(negedge SYSCLK);

        // Mid-operation reset during CMP: outputs clear before the next edge.
        set_ops(3, 8'h40, 8'h30);
        REQ[3] = 1'b1;
        @(negedge SYSCLK);
        check("pre_reset_cmp_a", CMP_A, 8'h40);
        #1 NSYSRESET = 1'b0;
        #1;
        check("async_reset_clear", {ACK, RESULT, BUSY, CMP_A, CMP_B}, 0);
        repeat (2) @(negedge SYSCLK);
        check("held_in_reset", {ACK, BUSY}, 0);
        push(4'b1000, 1'b1);
        NSYSRESET = 1'b1;
        wait_ack(3, lat);
        check("post_reset_latency", lat, 2);
        @(negedge SYSCLK);

        // Pointer wrap: after grant to 3, REQ=1001 must serve 0 first.
        set_ops(0, 8'h81, 8'h80);
        set_ops(3, 8'hFE, 8'hFF);
        push(4'b0001, 1'b1);
        push(4'b1000, 1'b0);
        REQ = 4'b1001;
        wait_ack(0, lat);
        check("wrap_first_latency", lat, 2);
        wait_ack(3, lat);
        check("wrap_second_latency", lat, 3);
        repeat (3) @(negedge SYSCLK);

        check("scoreboard_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sign_cmp_arbiter.md
Name: sign_cmp_arbiter

Overview:
- Round-robin scheduler that shares one signed 8-bit comparator (DataA, DataB -> AGEB; AGEB=1 when A>=B, two's complement) among NREQ requesters.
- Each requester presents an operand pair with a REQ/ACK handshake.
- The arbiter registers the granted operands onto the comparator inputs, samples AGEB one cycle later and returns the result with a one-cycle ACK.
- Sits between client logic and the single comparator instance at top level.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 8, operand width; must match the comparator.

Ports:
- SYSCLK  input  1  system clock, rising edge.
- NSYSRESET  input  1  asynchronous, active-low reset.
- REQ  input  NREQ  request per requester; held high until its ACK is seen.
- OPA  input  NREQ*WIDTH  operand A per requester; slice i = OPA[i*WIDTH +: WIDTH].
- OPB  input  NREQ*WIDTH  operand B per requester, same slicing.
- ACK  output  NREQ  one-hot, one-cycle completion pulse.
- RESULT  output  1  AGEB of the acknowledged transaction; valid while ACK!=0, held until the next capture.
- BUSY  output  1  high in CMP and DONE states.
- CMP_A  output  WIDTH  registered, drives comparator DataA.
- CMP_B  output  WIDTH  registered, drives comparator DataB.
- CMP_AGEB  input  1  comparator AGEB, combinational from CMP_A/CMP_B.

Behaviour:
- Reset (NSYSRESET=0, asynchronous): state=IDLE, ACK=0, RESULT=0, BUSY=0, CMP_A=0, CMP_B=0, round-robin pointer PTR=0, grant index G=0. Takes effect immediately, mid-transaction included. Any in-flight transaction is dropped with no ACK; the requester keeps REQ high and is re-arbitrated after reset release.
- FSM, 3 states, all transitions on rising SYSCLK:
  - IDLE: if REQ!=0, G = first i with REQ[i]=1, searching PTR, PTR+1, ... mod NREQ. Load CMP_A <= OPA slice G and CMP_B <= OPB slice G. Go to CMP. Else stay in IDLE.
  - CMP: comparator settles. At the edge, RESULT <= CMP_AGEB, ACK <= one-hot(G), PTR <= (G+1) mod NREQ. Go to DONE.
  - DONE: ACK high for this cycle only. At the edge, ACK <= 0 and go to IDLE.
- Latency: REQ sampled high at edge E -> ACK and RESULT valid from E+2 to E+3. Throughput is one compare per 3 cycles.
- Handshake:
  - The requester drops REQ on the edge ending its ACK cycle, so REQ is low when the FSM returns to IDLE.
  - Operands only need to be stable at the IDLE sampling edge; later changes have no effect.
  - If REQ is dropped early (after grant, before ACK), the transaction still completes and the ACK pulse is still issued.
  - If REQ is still high in IDLE after its ACK, it is treated as a new request.
- Fairness:
  - PTR advances only on completion.
  - With all REQ high, grants rotate 0,1,2,3,0,...
  - A continuously asserting requester cannot block the others for more than NREQ-1 transactions.
- Simultaneous events: new REQ edges arriving during CMP or DONE are ignored until IDLE. At most one ACK bit is ever high.
- CMP_A and CMP_B hold their values outside IDLE loads, so the comparator inputs are stable for the full CMP cycle.
- Arithmetic: no arithmetic in the arbiter; it slices operands and passes them through at width WIDTH. Signed comparison semantics belong entirely to the comparator.

Test Plan:
- Single request: REQ=0001, OPA0=8'hFF (-1), OPB0=8'h01 -> CMP_A=FF and CMP_B=01 one cycle after sampling; ACK=0001 for one cycle at E+2; RESULT=0.
- Signed boundary: requester 2 with OPA=8'h7F, OPB=8'h80 -> ACK=0100, RESULT=1. Repeat with 8'h80 vs 8'h7F -> RESULT=0. Equal operands 8'h80/8'h80 -> RESULT=1.
- All four REQ held high, each dropping on its ACK and re-raising next cycle -> ACK order 0001, 0010, 0100, 1000, 0001; exactly 3 cycles between successive ACKs; BUSY low only in IDLE.
- Early release: REQ1 dropped in the CMP cycle, OPA1 changed -> ACK=0010 still issued; RESULT reflects the operands sampled at grant.
- Mid-operation reset: assert NSYSRESET=0 during CMP -> ACK, RESULT, BUSY, CMP_A, CMP_B go to 0 immediately (before the next SYSCLK edge) and no ACK is issued. After release with REQ3 held -> requester 3 is granted (PTR=0 search) and ACK=1000 at E+2.
- Pointer wrap: grant requester 3, then REQ=1001 -> next grant is requester 0 (PTR wraps to 0), not requester 3.
